// File: rtl/branch_predictor_gshare.sv
// Direction predictor for the Fetcher: a table of saturating counters indexed by PC
// (bimodal) or PC XOR global history (gshare). The ROB trains it at commit and it keeps accuracy statistics.
module branch_predictor_gshare #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned IDX_W    = 6,
    parameter int unsigned CNT_W    = 2,
    parameter int unsigned HIST_W   = 6,
    parameter int unsigned MODE     = 1,
    parameter int unsigned PC_SHIFT = 2,
    parameter int unsigned STAT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   fet_pc,
    output logic              bp_pred,
    output logic [IDX_W-1:0]  bp_idx,
    input  logic              rob_bp_enable,
    input  logic [IDX_W-1:0]  rob_bp_idx,
    input  logic              rob_bp_jump,
    input  logic              rob_bp_correct,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] bp_correct_cnt,
    output logic [STAT_W-1:0] bp_total_cnt,
    output logic [HIST_W-1:0] bp_ghr
);

    localparam int unsigned      DEPTH    = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [CNT_W-1:0]  table_q [DEPTH];
    logic [HIST_W-1:0] ghr_q;
    logic [HIST_W-1:0] ghr_nxt;
    logic [STAT_W-1:0] correct_q;
    logic [STAT_W-1:0] total_q;
    logic [STAT_W-1:0] correct_nxt;
    logic [STAT_W-1:0] total_nxt;

    logic [IDX_W-1:0]  pcidx;
    logic [IDX_W-1:0]  ghr_ext;
    logic [CNT_W-1:0]  cnt_cur;
    logic [CNT_W-1:0]  cnt_upd;
    logic              unused_pc;

    // Only a window of the PC selects the entry; the remaining bits are deliberately ignored.
    assign unused_pc = ^fet_pc;
    assign pcidx     = fet_pc[PC_SHIFT +: IDX_W];
    assign ghr_ext   = IDX_W'(ghr_q);

    // Prediction reads the registered table, so a same-cycle update is seen one cycle later.
    always_comb begin
        bp_idx  = (MODE == 1) ? (pcidx ^ ghr_ext) : pcidx;
        bp_pred = table_q[bp_idx][CNT_W-1];
    end

    always_comb begin
        cnt_cur = table_q[rob_bp_idx];
        cnt_upd = cnt_cur;
        if (rob_bp_jump && (cnt_cur != CNT_MAX)) begin
            cnt_upd = cnt_cur + CNT_W'(1);
        end else if (!rob_bp_jump && (cnt_cur != '0)) begin
            cnt_upd = cnt_cur - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                table_q[i] <= CNT_INIT;
            end
        end else if (rob_bp_enable) begin
            table_q[rob_bp_idx] <= cnt_upd;
        end
    end

    // Committed outcomes only: the history is never speculative.
    generate
        if (HIST_W == 1) begin : g_hist1
            assign ghr_nxt = rob_bp_jump;
        end else begin : g_histn
            assign ghr_nxt = {ghr_q[HIST_W-2:0], rob_bp_jump};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else if (rob_bp_enable) begin
            ghr_q <= ghr_nxt;
        end
    end

    // Clear has priority over any increment in the same cycle; both counters saturate.
    always_comb begin
        correct_nxt = correct_q;
        total_nxt   = total_q;
        if (stat_clr) begin
            correct_nxt = '0;
            total_nxt   = '0;
        end else if (rob_bp_enable) begin
            if (total_q != STAT_MAX) begin
                total_nxt = total_q + STAT_W'(1);
            end
            if (rob_bp_correct && (correct_q != STAT_MAX)) begin
                correct_nxt = correct_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            correct_q <= '0;
            total_q   <= '0;
        end else begin
            correct_q <= correct_nxt;
            total_q   <= total_nxt;
        end
    end

    assign bp_correct_cnt = correct_q;
    assign bp_total_cnt   = total_q;
    assign bp_ghr         = ghr_q;

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Scoreboard bench: three predictors (gshare default, bimodal, 3-bit stats) driven by
// directed commits, with hand-computed expectations checked by a negedge monitor.
module tb_branch_predictor_gshare;

    localparam int F_PRED = 0;
    localparam int F_IDX  = 1;
    localparam int F_GHR  = 2;
    localparam int F_CORR = 3;
    localparam int F_TOT  = 4;

    typedef struct {
        string       name;
        int          d;
        int          f;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [2:0][31:0] pc;
    logic [2:0]       en;
    logic [2:0][5:0]  ridx;
    logic [2:0]       jmp;
    logic [2:0]       rcor;
    logic [2:0]       clr;
    logic [2:0]       pred;
    logic [2:0][5:0]  idx;
    logic [2:0][5:0]  ghr;
    logic [31:0]      cc0, tc0, cc1, tc1;
    logic [2:0]       cc2, tc2;

    exp_t        sb [$];
    exp_t        mon_e;
    logic [31:0] mon_act;
    int          checks = 0;
    int          passes = 0;

    branch_predictor_gshare #(.MODE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .fet_pc(pc[0]), .bp_pred(pred[0]), .bp_idx(idx[0]),
        .rob_bp_enable(en[0]), .rob_bp_idx(ridx[0]), .rob_bp_jump(jmp[0]),
        .rob_bp_correct(rcor[0]), .stat_clr(clr[0]), .bp_correct_cnt(cc0),
        .bp_total_cnt(tc0), .bp_ghr(ghr[0])
    );

    branch_predictor_gshare dut_g (
        .clk(clk), .rst_n(rst_n), .fet_pc(pc[1]), .bp_pred(pred[1]), .bp_idx(idx[1]),
        .rob_bp_enable(en[1]), .rob_bp_idx(ridx[1]), .rob_bp_jump(jmp[1]),
        .rob_bp_correct(rcor[1]), .stat_clr(clr[1]), .bp_correct_cnt(cc1),
        .bp_total_cnt(tc1), .bp_ghr(ghr[1])
    );

    branch_predictor_gshare #(.STAT_W(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .fet_pc(pc[2]), .bp_pred(pred[2]), .bp_idx(idx[2]),
        .rob_bp_enable(en[2]), .rob_bp_idx(ridx[2]), .rob_bp_jump(jmp[2]),
        .rob_bp_correct(rcor[2]), .stat_clr(clr[2]), .bp_correct_cnt(cc2),
        .bp_total_cnt(tc2), .bp_ghr(ghr[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] get(input int d, input int f);
        case (f)
            F_PRED:  return 32'(pred[d]);
            F_IDX:   return 32'(idx[d]);
            F_GHR:   return 32'(ghr[d]);
            F_CORR:  return (d == 0) ? cc0 : (d == 1) ? cc1 : 32'(cc2);
            default: return (d == 0) ? tc0 : (d == 1) ? tc1 : 32'(tc2);
        endcase
    endfunction

    // Monitor: outputs are compared half a cycle away from the active edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_e   = sb.pop_front();
            mon_act = get(mon_e.d, mon_e.f);
            checks++;
            if (mon_act === mon_e.exp) passes++;
            else $display("FAIL %s: got 0x%0h expected 0x%0h", mon_e.name, mon_act, mon_e.exp);
        end
    end

    task automatic expect_v(input string name, input int d, input int f, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.d    = d;
        e.f    = f;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input int d, input logic [5:0] i, input logic j, input logic c);
        en[d]   = 1'b1;
        ridx[d] = i;
        jmp[d]  = j;
        rcor[d] = c;
        tick();
        en[d] = 1'b0;
    endtask

    initial begin
        logic [9:0] pat;
        rst_n = 1'b0;
        pc = '0; en = '0; ridx = '0; jmp = '0; rcor = '0; clr = '0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        pc[1] = 32'h0000_0100;
        expect_v("rst_idx", 1, F_IDX, 32'h0);
        expect_v("rst_pred", 1, F_PRED, 32'h0);
        expect_v("rst_ghr", 1, F_GHR, 32'h0);
        expect_v("rst_corr", 1, F_CORR, 32'h0);
        expect_v("rst_tot", 1, F_TOT, 32'h0);
        expect_v("rst_tot_s", 2, F_TOT, 32'h0);
        tick();

        // Bimodal saturation on entry 5
        pc[0] = 32'h14;
        expect_v("bim_idx", 0, F_IDX, 32'h5);
        expect_v("bim_pred_init", 0, F_PRED, 32'h0);
        commit(0, 6'h05, 1'b1, 1'b0); expect_v("sat_up1", 0, F_PRED, 32'h1);
        commit(0, 6'h05, 1'b1, 1'b0); expect_v("sat_up2", 0, F_PRED, 32'h1);
        commit(0, 6'h05, 1'b1, 1'b0); expect_v("sat_up3", 0, F_PRED, 32'h1);
        commit(0, 6'h05, 1'b0, 1'b0); expect_v("sat_dn1", 0, F_PRED, 32'h1);
        commit(0, 6'h05, 1'b0, 1'b0); expect_v("sat_dn2", 0, F_PRED, 32'h0);
        commit(0, 6'h05, 1'b0, 1'b0); expect_v("sat_dn3", 0, F_PRED, 32'h0);
        commit(0, 6'h05, 1'b0, 1'b0); expect_v("sat_dn4", 0, F_PRED, 32'h0);
        commit(0, 6'h05, 1'b1, 1'b0); expect_v("sat_floor_up1", 0, F_PRED, 32'h0);
        commit(0, 6'h05, 1'b1, 1'b0); expect_v("sat_floor_up2", 0, F_PRED, 32'h1);
        expect_v("bim_ghr", 0, F_GHR, 32'h03);
        expect_v("bim_idx_nohist", 0, F_IDX, 32'h5);
        expect_v("bim_tot", 0, F_TOT, 32'd9);
        expect_v("bim_corr", 0, F_CORR, 32'd0);
        tick();

        // gshare indexing
        commit(1, 6'h3f, 1'b1, 1'b0);
        commit(1, 6'h3f, 1'b0, 1'b0);
        commit(1, 6'h3f, 1'b1, 1'b0);
        pc[1] = 32'h40;
        expect_v("gs_ghr101", 1, F_GHR, 32'h05);
        expect_v("gs_idx15", 1, F_IDX, 32'h15);
        expect_v("gs_pred0", 1, F_PRED, 32'h0);
        commit(1, 6'h15, 1'b1, 1'b0);
        pc[1] = 32'h78;
        expect_v("gs_idx15_b", 1, F_IDX, 32'h15);
        expect_v("gs_pred_b", 1, F_PRED, 32'h1);
        commit(1, 6'h15, 1'b1, 1'b0);
        pc[1] = 32'h08;
        expect_v("gs_idx15_c", 1, F_IDX, 32'h15);
        expect_v("gs_pred_c", 1, F_PRED, 32'h1);
        expect_v("gs_ghr_c", 1, F_GHR, 32'h17);
        tick();
        pc[1] = 32'h40;
        expect_v("gs_idx_moved", 1, F_IDX, 32'h07);
        expect_v("gs_pred_moved", 1, F_PRED, 32'h0);
        tick();

        // Same-cycle read and write of entry 0x20
        pc[1]   = 32'hDC;
        en[1]   = 1'b1;
        ridx[1] = 6'h20;
        jmp[1]  = 1'b1;
        rcor[1] = 1'b0;
        expect_v("byp_idx_old", 1, F_IDX, 32'h20);
        expect_v("byp_pred_old", 1, F_PRED, 32'h0);
        tick();
        en[1] = 1'b0;
        pc[1] = 32'h3C;
        expect_v("byp_idx_new", 1, F_IDX, 32'h20);
        expect_v("byp_pred_new", 1, F_PRED, 32'h1);
        expect_v("byp_ghr", 1, F_GHR, 32'h2F);
        tick();
        pc[1] = 32'hDC;
        expect_v("byp_idx_hist", 1, F_IDX, 32'h18);
        expect_v("byp_pred_hist", 1, F_PRED, 32'h0);
        tick();

        // Stats
        expect_v("st_tot6", 1, F_TOT, 32'd6);
        expect_v("st_corr0", 1, F_CORR, 32'd0);
        clr[1] = 1'b1;
        tick();
        clr[1] = 1'b0;
        expect_v("st_clr_tot", 1, F_TOT, 32'd0);
        pat = 10'b1011011011;
        for (int k = 0; k < 10; k++) commit(1, 6'h30, 1'b0, pat[k]);
        expect_v("st_tot10", 1, F_TOT, 32'd10);
        expect_v("st_corr7", 1, F_CORR, 32'd7);
        expect_v("st_ghr0", 1, F_GHR, 32'h0);
        clr[1] = 1'b1;
        commit(1, 6'h21, 1'b1, 1'b1);
        clr[1] = 1'b0;
        pc[1] = 32'h80;
        expect_v("clrupd_tot", 1, F_TOT, 32'd0);
        expect_v("clrupd_corr", 1, F_CORR, 32'd0);
        expect_v("clrupd_ghr", 1, F_GHR, 32'h01);
        expect_v("clrupd_idx", 1, F_IDX, 32'h21);
        expect_v("clrupd_pred", 1, F_PRED, 32'h1);
        tick();

        // 3-bit stat saturation
        for (int k = 0; k < 9; k++) begin
            commit(2, 6'h01, 1'b1, 1'(k >= 2));
            if (k == 6) begin
                expect_v("s3_tot7", 2, F_TOT, 32'd7);
                expect_v("s3_corr5", 2, F_CORR, 32'd5);
            end
        end
        expect_v("s3_tot_sat", 2, F_TOT, 32'd7);
        expect_v("s3_corr_sat", 2, F_CORR, 32'd7);
        tick();

        // Asynchronous reset in the middle of an update
        commit(1, 6'h21, 1'b1, 1'b1);
        expect_v("pre_rst_tot", 1, F_TOT, 32'd1);
        expect_v("pre_rst_ghr", 1, F_GHR, 32'h03);
        tick();
        pc[1]   = 32'h84;
        en[1]   = 1'b1;
        ridx[1] = 6'h21;
        jmp[1]  = 1'b0;
        rcor[1] = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        expect_v("arst_tot", 1, F_TOT, 32'd0);
        expect_v("arst_corr", 1, F_CORR, 32'd0);
        expect_v("arst_ghr", 1, F_GHR, 32'h0);
        expect_v("arst_idx", 1, F_IDX, 32'h21);
        expect_v("arst_pred", 1, F_PRED, 32'h0);
        expect_v("arst_bim_pred", 0, F_PRED, 32'h0);
        expect_v("arst_bim_ghr", 0, F_GHR, 32'h0);
        expect_v("arst_s_tot", 2, F_TOT, 32'd0);
        tick();
        en[1] = 1'b0;
        expect_v("arst_held_tot", 1, F_TOT, 32'd0);
        expect_v("arst_held_ghr", 1, F_GHR, 32'h0);
        tick();
        rst_n = 1'b1;
        expect_v("post_rst_tot", 1, F_TOT, 32'd0);
        expect_v("post_rst_pred", 1, F_PRED, 32'h0);
        tick();

        for (int w = 0; w < 4; w++) begin
            if (sb.size() == 0) break;
            tick();
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending expected 0 pending", sb.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
- Parametrised successor to the 2-bit bimodal predictor; direction predictor for the Fetcher, trained by the ROB at commit.
- Selectable indexing: bimodal (PC only) or gshare (PC XOR global history).
- Configurable table depth and counter width.
- Carries the table index back through the pipeline so the update hits exactly the entry that made the prediction.
- Keeps saturating, clearable aggregate accuracy counters.

Parameters:
- XLEN, 32, address width.
- IDX_W, 6, table index width; table depth = 2^IDX_W.
- CNT_W, 2, saturating counter width, 1..4.
- HIST_W, 6, global history width, 1..IDX_W.
- MODE, 1, 0 = bimodal, 1 = gshare.
- PC_SHIFT, 2, low PC bits dropped before indexing.
- STAT_W, 32, width of each accuracy counter.

Ports:
- clk, in, 1, clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- fet_pc, in, XLEN, PC of the instruction being fetched.
- bp_pred, out, 1, predicted taken (combinational).
- bp_idx, out, IDX_W, table index used for bp_pred; travels with the instruction to the ROB.
- rob_bp_enable, in, 1, commit of a conditional branch this cycle.
- rob_bp_idx, in, IDX_W, bp_idx captured at fetch for that branch.
- rob_bp_jump, in, 1, actual outcome: taken.
- rob_bp_correct, in, 1, the prediction was correct.
- stat_clr, in, 1, synchronous clear of the accuracy counters.
- bp_correct_cnt, out, STAT_W, correct predictions.
- bp_total_cnt, out, STAT_W, total committed branches.
- bp_ghr, out, HIST_W, current global history (debug).

Behaviour:
- Reset (rst_n low, asynchronous):
  - every counter = 2^(CNT_W-1)-1 (weakly not-taken; 2'b01 for CNT_W=2, 0 for CNT_W=1);
  - ghr = 0; both stat counters = 0.
  - Reset asserted mid-update: the update is discarded, all state returns to reset values.
- Index computation:
  - pcidx = fet_pc[PC_SHIFT+IDX_W-1 : PC_SHIFT].
  - MODE 0: bp_idx = pcidx.
  - MODE 1: bp_idx = pcidx XOR zero-extended ghr.
- Prediction: bp_pred = MSB of counter[bp_idx].
  - Purely combinational from fet_pc, the table and ghr; zero-cycle latency.
- Update, on posedge clk when rob_bp_enable=1, target entry = counter[rob_bp_idx]:
  - jump=1 and counter != all-ones: counter + 1.
  - jump=0 and counter != 0: counter - 1.
  - Otherwise unchanged; the counter saturates and never wraps.
- History:
  - On every update, ghr <= {ghr[HIST_W-2:0], rob_bp_jump}. For HIST_W=1, ghr <= rob_bp_jump.
  - ghr is non-speculative and is maintained in both modes; it only affects indexing when MODE=1.
  - No update means no ghr change.
- Same cycle read/write of one entry: bp_pred reflects the old value; the new value is visible from the next cycle.
  - ghr changes likewise become visible to bp_idx the cycle after the update.
- Accuracy counters, on posedge clk:
  - stat_clr=1: both counters <= 0, and any same-cycle stat increment is dropped. Clear wins. The table and ghr still update.
  - Otherwise, if rob_bp_enable: total += 1, and correct += rob_bp_correct.
  - Each counter saturates at 2^STAT_W-1 independently.
  - Invariant: bp_correct_cnt <= bp_total_cnt.
- rob_bp_correct affects only the stats, never the table.
- One update port; at most one update per cycle.

Test Plan:
1. Reset check, MODE=1, defaults: release rst_n, fet_pc=0x00000100 -> bp_idx=0x00, bp_pred=0, bp_ghr=0, both counts 0.
2. Saturation, MODE=0:
   - 3 updates idx 5, jump=1 -> counter 01→10→11→11; fet_pc=0x14 gives bp_pred=1 after the 1st update's edge.
   - 4 updates jump=0 -> 10,01,00,00; bp_pred=0 from the 2nd.
3. gshare indexing:
   - Commit jump pattern 1,0,1 -> bp_ghr=6'b000101.
   - fet_pc=0x00000040 (pcidx 0x10) -> bp_idx=0x15.
   - An update to rob_bp_idx=0x15 jump=1, twice -> bp_pred=1 for that PC.
4. Same-cycle bypass: fet_pc index equals rob_bp_idx with counter=01, jump=1 -> bp_pred=0 in that cycle, 1 in the next.
5. Stats:
   - 10 updates, 7 with correct=1 -> total=10, correct=7.
   - stat_clr together with an update -> both 0, table entry still incremented.
   - STAT_W=3: 9 updates -> total stays 7.
6. Async reset mid-run: assert rst_n low between edges during an update -> counts, ghr and table return to reset values immediately, with no clock edge needed.
